// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory and fills IF/ID. Define IF_MISALIGN_TRAP_EN to trap misaligned fetches.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        if_id_exc
);

`ifdef IF_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
`ifdef IF_MISALIGN_TRAP_EN
        ,
        TRAP  = 2'd3
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        exc;
    } if_id_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] saved_q, saved_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    if_id_t      if_id_q, if_id_d;
    logic        imem_req_q, imem_req_d;
    if_id_t      bubble;

    // Misaligned PCs only matter when the trap feature is built in.
    function automatic logic fetch_blocked(input logic [31:0] pc);
        return TRAP_EN && (pc[1:0] != 2'b00);
    endfunction

    assign bubble = '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0, exc: 1'b0};

    // NOTE: every _d gets a default from its _q first, so no path through the
    // case below can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        saved_d      = saved_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if_id_d      = if_id_q;

        case (state_q)
            FETCH: begin
`ifdef IF_MISALIGN_TRAP_EN
                if (fetch_blocked(pc_q)) begin
                    if (flush) begin
                        if_id_d = bubble;
                        pc_d    = npc;
                    end else if (!stall) begin
                        if_id_d = '{pc: pc_q, instr: NOP_INSTR, valid: 1'b1, exc: 1'b1};
                        state_d = TRAP;
                    end
                end else
`endif
                if (flush) begin
                    if_id_d = bubble;
                    if (imem_ack) begin
                        pc_d = npc;
                    end else begin
                        // The outstanding request must complete before redirecting.
                        saved_d = npc;
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = HOLD;
                    end else begin
                        if_id_d = '{pc: pc_q, instr: imem_rdata, valid: 1'b1, exc: 1'b0};
                        pc_d    = npc;
                    end
                end else if (!stall) begin
                    if_id_d = bubble;
                end
            end

            HOLD: begin
                if (flush) begin
                    if_id_d = bubble;
                    pc_d    = npc;
                    state_d = FETCH;
                end else if (!stall) begin
                    if_id_d = '{pc: skid_pc_q, instr: skid_instr_q, valid: 1'b1, exc: 1'b0};
                    pc_d    = npc;
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                if_id_d = bubble;
                if (flush) begin
                    saved_d = npc;
                end
                if (imem_ack) begin
                    pc_d    = flush ? npc : saved_q;
                    state_d = FETCH;
                end
            end

`ifdef IF_MISALIGN_TRAP_EN
            TRAP: begin
                if (flush) begin
                    if_id_d = bubble;
                    pc_d    = npc;
                    state_d = FETCH;
                end
            end
`endif

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Request is registered: derived from the state and PC we are about to hold.
    always_comb begin
        imem_req_d = 1'b0;
        case (state_d)
            FETCH:   imem_req_d = !fetch_blocked(pc_d);
            DRAIN:   imem_req_d = 1'b1;
            default: imem_req_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            saved_q      <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            if_id_q      <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0, exc: 1'b0};
            imem_req_q   <= !fetch_blocked(RESET_PC);
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            saved_q      <= saved_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            if_id_q      <= if_id_d;
            imem_req_q   <= imem_req_d;
        end
    end

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;
    assign if_id_exc   = TRAP_EN && if_id_q.exc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: bench drives npc and plays the instruction
// memory, expected values are hand-computed per scenario.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic [31:0] pc_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        if_id_exc;

    int errors = 0;
    int checks = 0;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .stall      (stall),
        .flush      (flush),
        .pc_out     (pc_out),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .if_id_exc  (if_id_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; npc = 32'h0; stall = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        cyc(); cyc();
        checks++;
        if (pc_out !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_pc: got pc=%h addr=%h req=%b expected pc=0 addr=0 req=1",
                     pc_out, imem_addr, imem_req);
        end
        checks++;
        if (if_id_pc !== 32'h0 || if_id_instr !== NOP || if_id_valid !== 1'b0 || if_id_exc !== 1'b0) begin
            errors++;
            $display("FAIL reset_if_id: got pc=%h instr=%h v=%b exc=%b expected 0/%h/0/0",
                     if_id_pc, if_id_instr, if_id_valid, if_id_exc, NOP);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i) * 4;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                errors++;
                $display("FAIL zw_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h",
                         i, imem_req, imem_addr, a);
            end
            imem_ack = 1'b1; imem_rdata = 32'h1000_0000 + a; npc = a + 4;
            cyc();
            checks++;
            if (if_id_pc !== a || if_id_instr !== 32'h1000_0000 + a || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL zw_if_id[%0d]: got %h/%h/%b expected %h/%h/1",
                         i, if_id_pc, if_id_instr, if_id_valid, a, 32'h1000_0000 + a);
            end
        end
    endtask

    task automatic test_wait_states();
        imem_ack = 1'b0; npc = 32'h14;
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h10) begin
                errors++;
                $display("FAIL ws_bubble[%0d]: got v=%b instr=%h addr=%h expected 0/%h/10",
                         k, if_id_valid, if_id_instr, imem_addr, NOP);
            end
        end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        checks++;
        if (if_id_pc !== 32'h10 || if_id_instr !== 32'h1234_5678 || if_id_valid !== 1'b1 || pc_out !== 32'h14) begin
            errors++;
            $display("FAIL ws_deliver: got %h/%h/%b pc=%h expected 10/12345678/1 pc=14",
                     if_id_pc, if_id_instr, if_id_valid, pc_out);
        end
    endtask

    task automatic test_stall_hold();
        imem_ack = 1'b1; imem_rdata = 32'h1000_0014; npc = 32'h20;
        cyc();
        stall = 1'b1; imem_rdata = 32'h0050_0093; npc = 32'h24;
        cyc();
        checks++;
        if (if_id_pc !== 32'h14 || if_id_valid !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h20) begin
            errors++;
            $display("FAIL hold_enter: got if_id_pc=%h v=%b req=%b pc=%h expected 14/1/0/20",
                     if_id_pc, if_id_valid, imem_req, pc_out);
        end
        imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        cyc();
        checks++;
        if (if_id_pc !== 32'h14 || if_id_instr !== 32'h1000_0014 || pc_out !== 32'h20) begin
            errors++;
            $display("FAIL hold_keep: got %h/%h pc=%h expected 14/10000014 pc=20",
                     if_id_pc, if_id_instr, pc_out);
        end
        stall = 1'b0;
        cyc();
        checks++;
        if (if_id_pc !== 32'h20 || if_id_instr !== 32'h0050_0093 || if_id_valid !== 1'b1 ||
            pc_out !== 32'h24 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got %h/%h/%b pc=%h req=%b expected 20/00500093/1 pc=24 req=1",
                     if_id_pc, if_id_instr, if_id_valid, pc_out, imem_req);
        end
    endtask

    task automatic test_flush_drain();
        imem_ack = 1'b1; imem_rdata = 32'h1000_0024; npc = 32'h40;
        cyc();
        imem_ack = 1'b0; flush = 1'b1; npc = 32'h80;
        cyc();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL drain_enter: got v=%b instr=%h req=%b addr=%h expected 0/%h/1/40",
                     if_id_valid, if_id_instr, imem_req, imem_addr, NOP);
        end
        npc = 32'h100;
        cyc();
        flush = 1'b0; stall = 1'b1; npc = 32'h0BAD_0000;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_wait: got req=%b addr=%h v=%b expected 1/40/0",
                     imem_req, imem_addr, if_id_valid);
        end
        stall = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        checks++;
        if (pc_out !== 32'h100 || imem_addr !== 32'h100 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            errors++;
            $display("FAIL drain_done: got pc=%h addr=%h v=%b instr=%h expected 100/100/0/%h",
                     pc_out, imem_addr, if_id_valid, if_id_instr, NOP);
        end
        imem_rdata = 32'h1000_0100; npc = 32'h104;
        cyc();
        checks++;
        if (if_id_pc !== 32'h100 || if_id_instr !== 32'h1000_0100 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_resume: got %h/%h/%b expected 100/10000100/1",
                     if_id_pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_flush_stall();
        imem_ack = 1'b1; flush = 1'b1; stall = 1'b1; npc = 32'h200; imem_rdata = 32'h0000_0BAD;
        cyc();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || pc_out !== 32'h200 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall: got v=%b instr=%h pc=%h req=%b expected 0/%h/200/1",
                     if_id_valid, if_id_instr, pc_out, imem_req, NOP);
        end
        flush = 1'b0; stall = 1'b1; imem_rdata = 32'h1000_0200; npc = 32'h204;
        cyc();
        imem_ack = 1'b0; flush = 1'b1; npc = 32'h300;
        cyc();
        checks++;
        if (pc_out !== 32'h300 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_flush: got pc=%h req=%b v=%b expected 300/1/0",
                     pc_out, imem_req, if_id_valid);
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_misalign();
        imem_ack = 1'b1; imem_rdata = 32'h1000_0300; npc = 32'h302;
        cyc();
`ifdef IF_MISALIGN_TRAP_EN
        checks++;
        if (imem_req !== 1'b0 || pc_out !== 32'h302) begin
            errors++;
            $display("FAIL trap_noreq: got req=%b pc=%h expected 0/302", imem_req, pc_out);
        end
        imem_ack = 1'b0; npc = 32'h306;
        cyc(); cyc();
        checks++;
        if (if_id_pc !== 32'h302 || if_id_instr !== NOP || if_id_valid !== 1'b1 ||
            if_id_exc !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h302) begin
            errors++;
            $display("FAIL trap_entry: got %h/%h/%b/%b req=%b pc=%h expected 302/%h/1/1 req=0 pc=302",
                     if_id_pc, if_id_instr, if_id_valid, if_id_exc, imem_req, pc_out, NOP);
        end
        flush = 1'b1; npc = 32'h400;
        cyc();
        checks++;
        if (pc_out !== 32'h400 || imem_req !== 1'b1 || if_id_valid !== 1'b0 || if_id_exc !== 1'b0) begin
            errors++;
            $display("FAIL trap_exit: got pc=%h req=%b v=%b exc=%b expected 400/1/0/0",
                     pc_out, imem_req, if_id_valid, if_id_exc);
        end
        flush = 1'b0;
`else
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h302) begin
            errors++;
            $display("FAIL misalign_req: got req=%b addr=%h expected 1/302", imem_req, imem_addr);
        end
        imem_rdata = 32'h1000_0302; npc = 32'h306;
        cyc();
        checks++;
        if (if_id_pc !== 32'h302 || if_id_instr !== 32'h1000_0302 || if_id_valid !== 1'b1 || if_id_exc !== 1'b0) begin
            errors++;
            $display("FAIL misalign_fetch: got %h/%h/%b/%b expected 302/10000302/1/0",
                     if_id_pc, if_id_instr, if_id_valid, if_id_exc);
        end
`endif
    endtask

    task automatic test_reset_midrequest();
        imem_ack = 1'b0; flush = 1'b1; npc = 32'h500;
        cyc();
        flush = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (pc_out !== 32'h0 || imem_req !== 1'b1 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got pc=%h req=%b v=%b if_id_pc=%h expected 0/1/0/0",
                     pc_out, imem_req, if_id_valid, if_id_pc);
        end
        npc = 32'h4; imem_ack = 1'b1; imem_rdata = 32'h1000_0000;
        cyc();
        checks++;
        if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || pc_out !== 32'h4) begin
            errors++;
            $display("FAIL reset_mid_resume: got %h/%b pc=%h expected 0/1/4",
                     if_id_pc, if_id_valid, pc_out);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_flush_drain();
        test_flush_stall();
        test_misalign();
        test_reset_midrequest();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core.
- Holds the architectural PC and presents it to the next-PC logic; loads the next-PC result each advancing cycle.
- Issues requests to a variable-latency instruction memory and fills the IF/ID pipeline register.
- Handles stall, flush/redirect and in-flight request draining.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- npc  in  32  next PC from next-PC logic (PC+4, branch or jump target).
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  taken redirect from EX. npc holds the target. Overrides stall.
- pc_out  out  32  current PC, fed to the next-PC logic.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  memory returns data this cycle; only valid while imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_exc  out  1  IF/ID entry is a misaligned-fetch trap (optional feature).

Behaviour:
- All state updates on the rising edge of clk.
- **Reset:** rst=1 forces:
  - pc=RESET_PC, state=FETCH.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, if_id_exc=0.
  - Skid buffer empty, saved target=0.
  - Reset mid-request abandons the request. The memory must tolerate a request dropped by reset.
- **States:** FETCH, HOLD, DRAIN, TRAP (TRAP only with the macro).
- **Outputs by state:**
  - imem_req=1 in FETCH and DRAIN, else 0.
  - imem_addr=pc in all states.
  - pc_out=pc.
- **FETCH, no flush:**
  - ack & !stall: IF/ID<={pc, rdata, valid=1}; pc<=npc.
  - ack & stall: rdata and pc go to the skid buffer; IF/ID unchanged; go HOLD; pc unchanged.
  - !ack & !stall: IF/ID<={pc, NOP_INSTR, valid=0} (bubble); pc unchanged.
  - !ack & stall: IF/ID unchanged.
- **HOLD:**
  - !stall: IF/ID<=buffer with valid=1; pc<=npc; go FETCH.
  - stall: hold everything.
- **Flush rules:**
  - IF/ID is always cleared to {pc, NOP_INSTR, 0, 0}.
  - FETCH with ack: discard rdata; pc<=npc; stay FETCH.
  - FETCH without ack: saved<=npc; go DRAIN. Request stays asserted at the old pc; a request is never abandoned except by reset.
  - HOLD: discard buffer; pc<=npc; go FETCH.
  - DRAIN: saved<=npc (latest redirect wins).
- **DRAIN:**
  - On ack: discard rdata; pc<=saved; go FETCH.
  - IF/ID holds the bubble throughout.
  - stall is ignored.
- **Throughput and arithmetic:**
  - Zero-wait memory (ack same cycle as req) sustains one instruction per cycle.
  - Latency is pc-to-IF/ID = 1 edge after ack.
  - No wrap checking; pc is 32-bit modulo.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- **Defined:**
  - In FETCH with pc[1:0]!=0, imem_req=0.
  - If !stall: IF/ID<={pc, NOP_INSTR, valid=1, exc=1}; go TRAP.
  - TRAP: imem_req=0; IF/ID holds the trap entry until flush; then pc<=npc and go FETCH.
- **Undefined:**
  - No alignment check; pc[1:0] is fetched as-is.
  - if_id_exc is tied 0 and the TRAP state does not exist.

Test Plan:
- Reset with RESET_PC=32'h0000_0000, zero-wait memory, npc=pc+4 → imem_addr sequence 0,4,8,C on consecutive cycles; IF/ID valid=1 one cycle later each, with matching if_id_pc.
- Memory acks after 3 cycles at pc=0x10 → two bubbles (valid=0, instr=0x00000013), then IF/ID={0x10, rdata, 1}; pc becomes 0x14.
- stall=1 on the ack cycle at pc=0x20 with rdata=0x00500093 → IF/ID unchanged and HOLD entered. After 2 stalled cycles, stall=0 → IF/ID={0x20, 0x00500093, 1}; pc=npc.
- flush with npc=0x100 while the request at 0x40 is outstanding → imem_addr stays 0x40 until ack and data is dropped. Next request addr=0x100; no instruction from 0x40 ever reaches IF/ID valid.
- flush and stall together, with ack, npc=0x200 → IF/ID valid=0; pc=0x200 next cycle.
- With IF_MISALIGN_TRAP_EN, npc=0x302 → no imem_req at 0x302. IF/ID={0x302, NOP, valid=1, exc=1} is held until flush with npc=0x400 resumes fetch at 0x400.
